// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: dispenser state encodings, coin indices
// and denomination values. Field order everywhere is {50,20,10,5,1}, MSB = 50.
package vending_pkg;

    localparam int N_DENOM = 5;

    // Coin index doubles as the bit position in one-hot coin vectors.
    typedef enum logic [2:0] {
        COIN_1  = 3'd0,
        COIN_5  = 3'd1,
        COIN_10 = 3'd2,
        COIN_20 = 3'd3,
        COIN_50 = 3'd4
    } coin_e;

    localparam logic [4:0] ST_IDLE   = 5'h01;
    localparam logic [4:0] ST_SELECT = 5'h02;
    localparam logic [4:0] ST_EJECT  = 5'h04;
    localparam logic [4:0] ST_GAP    = 5'h08;
    localparam logic [4:0] ST_DONE   = 5'h10;

    function automatic logic [7:0] denom_value(input coin_e c);
        case (c)
            COIN_50: denom_value = 8'd50;
            COIN_20: denom_value = 8'd20;
            COIN_10: denom_value = 8'd10;
            COIN_5:  denom_value = 8'd5;
            default: denom_value = 8'd1;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending FSM / coin hopper and the change dispenser.
// The master side drives requests and hopper acks; the slave is the dispenser.
interface change_dispenser_if #(
    parameter int INV_W = 4
);
    logic               start;
    logic [7:0]         amount;
    logic               abort;
    logic               refill;
    logic               eject_ack;
    logic [4:0]         eject_req;
    logic               busy;
    logic               done;
    logic               short;
    logic [7:0]         remaining;
    logic [5*INV_W-1:0] inv_flat;
    logic [4:0]         state_out;

    modport master (
        output start, amount, abort, refill, eject_ack,
        input  eject_req, busy, done, short, remaining, inv_flat, state_out
    );

    modport slave (
        input  start, amount, abort, refill, eject_ack,
        output eject_req, busy, done, short, remaining, inv_flat, state_out
    );
endinterface

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: bulk refill load, single-index decrement,
// and a nonzero vector the greedy selector uses to skip empty tubes.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int INV_W    = 4,
    parameter int INV_INIT = 10
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     refill_i,
    input  logic                     dec_en_i,
    input  coin_e                    dec_idx_i,
    output logic [N_DENOM*INV_W-1:0] inv_flat_o,
    output logic [N_DENOM-1:0]       nonzero_o
);

    logic [INV_W-1:0] cnt_q [N_DENOM];
    logic [INV_W-1:0] cnt_d [N_DENOM];

    always_comb begin
        for (int i = 0; i < N_DENOM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (refill_i) begin
                cnt_d[i] = INV_W'(INV_INIT);
            end else if (dec_en_i && (dec_idx_i == coin_e'(i))) begin
                cnt_d[i] = cnt_q[i] - INV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_DENOM; i++) cnt_q[i] <= INV_W'(INV_INIT);
        end else begin
            for (int i = 0; i < N_DENOM; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        inv_flat_o = '0;
        nonzero_o  = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            inv_flat_o[i*INV_W +: INV_W] = cnt_q[i];
            nonzero_o[i]                 = |cnt_q[i];
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays `amount` one coin at a time over a req/ack
// hopper handshake, flagging a shortfall when the greedy pick runs dry.
//   state  | meaning
//   IDLE   | waiting for start; refill allowed
//   SELECT | pick largest payable coin, or finish
//   EJECT  | hold one-hot eject_req until hopper ack
//   GAP    | GAP_CYC idle cycles between coins
//   DONE   | one-cycle done pulse
module change_dispenser
    import vending_pkg::*;
#(
    parameter int INV_W    = 4,
    parameter int INV_INIT = 10,
    parameter int GAP_CYC  = 2
)(
    input  logic sys_clk,
    input  logic sys_rst_n,    // active-high despite the legacy name
    change_dispenser_if.slave dsp
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [4:0]         state_q, state_d;
    logic [7:0]         rem_q, rem_d;
    logic               short_q, short_d;
    coin_e              sel_q, sel_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               dec_en, refill_en;
    logic [N_DENOM-1:0] nonzero;
    logic               found;
    coin_e              pick;

    coin_inventory #(
        .INV_W    (INV_W),
        .INV_INIT (INV_INIT)
    ) u_inv (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst_n),
        .refill_i   (refill_en),
        .dec_en_i   (dec_en),
        .dec_idx_i  (sel_q),
        .inv_flat_o (dsp.inv_flat),
        .nonzero_o  (nonzero)
    );

    // Ascending scan, so the last hit is the largest payable denomination.
    always_comb begin
        found = 1'b0;
        pick  = COIN_1;
        for (int i = 0; i < N_DENOM; i++) begin
            if (nonzero[i] && (denom_value(coin_e'(i)) <= rem_q)) begin
                found = 1'b1;
                pick  = coin_e'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        short_d   = short_q;
        sel_d     = sel_q;
        gap_d     = gap_q;
        dec_en    = 1'b0;
        refill_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dsp.start) begin
                    rem_d   = dsp.amount;
                    short_d = 1'b0;
                    state_d = ST_SELECT;
                end else if (dsp.refill) begin
                    refill_en = 1'b1;
                end
            end
            ST_SELECT: begin
                if (dsp.abort) begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end else if (rem_q == 8'd0) begin
                    state_d = ST_DONE;
                end else if (found) begin
                    sel_d   = pick;
                    state_d = ST_EJECT;
                end else begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                // Abort outranks a same-cycle ack: the coin is not booked.
                if (dsp.abort) begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end else if (dsp.eject_ack) begin
                    rem_d   = rem_q - denom_value(sel_q);
                    dec_en  = 1'b1;
                    gap_d   = GW'(GAP_CYC - 1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (dsp.abort) begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end else if (gap_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 8'd0;
            short_q <= 1'b0;
            sel_q   <= COIN_1;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
        end
    end

    assign dsp.eject_req = (state_q == ST_EJECT) ? (5'b00001 << sel_q) : 5'b00000;
    assign dsp.busy      = (state_q != ST_IDLE);
    assign dsp.done      = (state_q == ST_DONE);
    assign dsp.short     = short_q;
    assign dsp.remaining = rem_q;
    assign dsp.state_out = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random transactions,
// checked against a greedy coin-payment model with its own inventory.
module tb_change_dispenser;

    localparam int INV_W    = 4;
    localparam int INV_INIT = 10;
    localparam int GAP_CYC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.INV_W(INV_W)) bus();

    change_dispenser #(
        .INV_W    (INV_W),
        .INV_INIT (INV_INIT),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst),
        .dsp       (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int dv[5]      = '{1, 5, 10, 20, 50};
    int mdl_inv[5] = '{10, 10, 10, 10, 10};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_flat();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 5; i++) f[i*INV_W +: INV_W] = mdl_inv[i][INV_W-1:0];
        return f;
    endfunction

    task automatic do_refill();
        @(negedge clk);
        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        for (int i = 0; i < 5; i++) mdl_inv[i] = INV_INIT;
        chk("refill_inv", bus.inv_flat, mdl_flat());
    endtask

    // abort_coin: index of the coin whose EJECT receives abort (+ack), -1 = none.
    task automatic run_txn(input logic [7:0] amt, input int abort_coin,
                           input bit with_refill, input bit busy_poke);
        int  exp_coin[$];
        int  tinv[5];
        int  rem, run_rem, pick, cyc, last_ack, coin_i, lat;
        bit  exp_short, done_seen, aborted;
        logic [4:0] req_seen;

        rem = amt;
        exp_short = 1'b0;
        for (int i = 0; i < 5; i++) tinv[i] = mdl_inv[i];
        while (rem > 0) begin
            pick = -1;
            for (int i = 4; i >= 0; i--)
                if (pick < 0 && dv[i] <= rem && tinv[i] > 0) pick = i;
            if (pick < 0) begin
                exp_short = 1'b1;
                break;
            end
            exp_coin.push_back(pick);
            tinv[pick]--;
            rem -= dv[pick];
        end

        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = amt;
        bus.refill = with_refill;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.refill = 1'b0;
        bus.amount = 8'($urandom);
        cyc = 1;
        chk("select_after_start", bus.state_out, 5'h02);
        chk("short_cleared", bus.short, 1'b0);
        chk("start_refill_dropped", bus.inv_flat, mdl_flat());

        run_rem   = amt;
        last_ack  = 0;
        coin_i    = 0;
        done_seen = 1'b0;
        aborted   = 1'b0;
        while (!done_seen && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                done_seen = 1'b1;
                if (coin_i == 0) chk("done_latency", cyc, 2);
                else             chk("done_after_gap", cyc - last_ack, GAP_CYC + 1);
            end else if (bus.eject_req != 5'd0) begin
                if (coin_i < exp_coin.size()) chk("coin", bus.eject_req, 1 << exp_coin[coin_i]);
                else                          chk("extra_coin", bus.eject_req, 0);
                if (coin_i == 0) chk("first_req_latency", cyc, 2);
                else             chk("coin_gap", cyc - last_ack, GAP_CYC + 1);
                req_seen = bus.eject_req;
                lat = $urandom_range(0, 2);
                repeat (lat) begin
                    @(negedge clk);
                    cyc++;
                    chk("req_hold", bus.eject_req, req_seen);
                end
                if (coin_i == abort_coin) begin
                    bus.abort = 1'b1;
                    aborted   = 1'b1;
                end
                bus.eject_ack = 1'b1;
                @(negedge clk);
                cyc++;
                bus.eject_ack = 1'b0;
                bus.abort     = 1'b0;
                chk("req_drop", bus.eject_req, 0);
                if (!aborted && coin_i < exp_coin.size()) begin
                    run_rem -= dv[exp_coin[coin_i]];
                    mdl_inv[exp_coin[coin_i]]--;
                end
                chk("remaining_step", bus.remaining, run_rem);
                last_ack = cyc;
                coin_i++;
                if (aborted) begin
                    chk("abort_to_done", bus.done, 1'b1);
                    done_seen = 1'b1;
                end else if (busy_poke && coin_i == 1) begin
                    bus.start  = 1'b1;
                    bus.refill = 1'b1;
                    bus.amount = 8'd200;
                    @(negedge clk);
                    cyc++;
                    bus.start  = 1'b0;
                    bus.refill = 1'b0;
                    chk("poke_ignored_inv", bus.inv_flat, mdl_flat());
                    chk("poke_ignored_rem", bus.remaining, run_rem);
                end
            end
        end
        chk("done_seen", done_seen, 1'b1);
        if (aborted) begin
            exp_short = 1'b1;
            chk("coin_count", coin_i, abort_coin + 1);
        end else begin
            chk("coin_count", coin_i, exp_coin.size());
        end
        chk("short", bus.short, exp_short);
        chk("remaining_final", bus.remaining, run_rem);
        chk("inv", bus.inv_flat, mdl_flat());
        chk("busy_in_done", bus.busy, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
        chk("busy_fall", bus.busy, 1'b0);
        chk("back_idle", bus.state_out, 5'h01);
        chk("short_sticky", bus.short, exp_short);
    endtask

    initial begin
        int w;
        bus.start     = 1'b0;
        bus.amount    = 8'd0;
        bus.abort     = 1'b0;
        bus.refill    = 1'b0;
        bus.eject_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", bus.state_out, 5'h01);
        chk("rst_req", bus.eject_req, 0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_short", bus.short, 1'b0);
        chk("rst_rem", bus.remaining, 0);
        chk("rst_inv", bus.inv_flat, 20'hAAAAA);
        rst = 1'b0;

        // Greedy 78 -> 50,20,5,1,1,1 ; then zero amount
        run_txn(8'd78, -1, 1'b0, 1'b0);
        chk("inv_50_after_78", bus.inv_flat[19:16], 4'd9);
        chk("inv_1_after_78", bus.inv_flat[3:0], 4'd7);
        run_txn(8'd0, -1, 1'b0, 1'b0);

        // Fallback with no tens: 30 -> 20,5,5
        do_refill();
        repeat (10) run_txn(8'd10, -1, 1'b0, 1'b0);
        run_txn(8'd30, -1, 1'b0, 1'b0);

        // Shortfall with no fives and no ones: 23 -> 20, short, remaining 3
        do_refill();
        repeat (10) run_txn(8'd5, -1, 1'b0, 1'b0);
        repeat (2) run_txn(8'd4, -1, 1'b0, 1'b0);
        run_txn(8'd2, -1, 1'b0, 1'b0);
        run_txn(8'd23, -1, 1'b0, 1'b0);
        chk("shortfall_rem", bus.remaining, 3);

        // Abort during second EJECT of 78, then start while busy is ignored
        do_refill();
        run_txn(8'd78, 1, 1'b0, 1'b0);
        chk("abort_rem", bus.remaining, 28);
        do_refill();
        run_txn(8'd66, -1, 1'b0, 1'b1);

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) do_refill();
            run_txn(8'($urandom_range(0, 130)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                    1'($urandom_range(0, 3) == 0), 1'b0);
        end

        // Async reset in the middle of an EJECT
        do_refill();
        run_txn(8'd78, -1, 1'b0, 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = 8'd60;
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (bus.eject_req == 5'd0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_pre_req", bus.eject_req, 5'b10000);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) mdl_inv[i] = INV_INIT;
        chk("async_rst_req", bus.eject_req, 0);
        chk("async_rst_state", bus.state_out, 5'h01);
        chk("async_rst_rem", bus.remaining, 0);
        chk("async_rst_inv", bus.inv_flat, mdl_flat());
        @(negedge clk);
        rst = 1'b0;
        run_txn(8'd99, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-dispensing back end for the micro-vending machine. It takes the change amount computed by the vending FSM, ejects coins greedily (50/20/10/5/1) through a req/ack handshake with the coin hopper, and keeps a per-denomination inventory. It reports completion or a shortfall when the remaining amount cannot be paid.

## Interface
Parameters:
- INV_W, 4: width of each inventory counter.
- INV_INIT, 10: count loaded into every denomination on reset or refill; must be ≤ 2^INV_W−1.
- GAP_CYC, 2: idle cycles between coins; must be ≥ 1.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: latch `amount` and begin dispensing.
- amount  in  8  change to pay, in units of 1.
- abort  in  1  stop dispensing; finish with shortfall.
- refill  in  1  reload all inventory counters to INV_INIT.
- eject_ack  in  1  hopper has ejected the requested coin.
- eject_req  out  5  one-hot coin request {50,20,10,5,1}, MSB = 50.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- short  out  1  sticky shortfall flag; cleared by the next accepted start.
- remaining  out  8  amount still unpaid.
- inv_flat  out  5*INV_W  inventory {50,20,10,5,1}, MSB field = 50.
- state_out  out  5  one-hot state.

## Operation
- States: IDLE=01h, SELECT=02h, EJECT=04h, GAP=08h, DONE=10h.
- IDLE
  - If start=1: remaining←amount, short←0, go to SELECT.
  - Else if refill=1: every inventory counter←INV_INIT.
- SELECT
  - If remaining==0, go to DONE.
  - Else pick the largest denomination d with d≤remaining and inv[d]>0, latch it, and go to EJECT.
  - If no denomination qualifies: short←1, go to DONE.
- EJECT
  - eject_req = one-hot of d, held stable.
  - On eject_ack: remaining←remaining−d, inv[d]←inv[d]−1, go to GAP.
- GAP: wait GAP_CYC cycles, then go to SELECT.
- DONE: done=1 for one cycle, then go to IDLE.
- abort in SELECT, EJECT or GAP: short←1, go to DONE.
  - eject_ack in the same cycle is ignored; no decrement occurs.
- start is ignored unless in IDLE. refill is ignored unless in IDLE. If start and refill arrive together, start wins and refill is dropped.
- eject_ack outside EJECT is ignored.
- Subtractions never underflow, because the selection rule guarantees d≤remaining and inv[d]>0.
- Greedy only, with no backtracking. A shortfall is reported even when a non-greedy solution would exist.

## Timing
- Reset values: state IDLE, eject_req=0, busy=0, done=0, short=0, remaining=0, all inventory counters=INV_INIT.
- Reset is asynchronous. Asserting it mid-EJECT drops eject_req in the same cycle.
- All outputs are registered or decoded directly from state registers; there are no combinational input-to-output paths.
- start sampled at edge T → SELECT at T+1 → EJECT at T+2 (eject_req high from T+2).
- eject_ack sampled at edge A → at A+1, eject_req=0 and remaining/inv are updated. GAP occupies A+1 … A+GAP_CYC, and SELECT follows.
- Per-coin cost is 1 (SELECT) + ack latency + GAP_CYC cycles.
- amount=0: done high at T+2, no eject.
- busy falls in the cycle after DONE.

## Structure
- Shared package (vending_pkg) holds:
  - state encodings;
  - denomination values 50/20/10/5/1 and their one-hot index order;
  - the {50,20,10,5,1} field-ordering convention, shared with the vending FSM's coin inputs.
- One natural sub-module, coin_inventory: five INV_W counters with a refill load, a single-index decrement, and a "nonzero" vector output used by SELECT.
- The FSM, greedy selector and gap counter stay in change_dispenser.

## Test plan
- Greedy pay: full inventory, amount=78, ack 1 cycle after each req → requests 50,20,5,1,1,1; remaining 0; done pulse; short=0; inv_50=9, inv_1=7.
- Zero: amount=0 → done at T+2, eject_req never asserted, short=0.
- Fallback: inv_10=0, amount=30 → requests 20,5,5; short=0.
- Shortfall: inv_5=0 and inv_1=0, amount=23 → eject 20 only; short=1; remaining=3; done pulse.
- Abort and ignore: abort during the second EJECT of amount=78 → no ack counted, short=1, remaining=28. Then refill restores all counters to 10; start while busy is ignored.
- Async reset asserted mid-EJECT → eject_req drops immediately, state IDLE, inventory back to INV_INIT, remaining=0.
